// File: rtl/tick_acc_pkg.sv
// Shared types and defaults for the tick accumulator slice.
package tick_acc_pkg;

  localparam int unsigned DefaultAccW = 8;
  // Matches the width of the upstream 4-bit counter.
  localparam int unsigned CntW = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the upstream counter terminal pulse.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic rise
);

  logic tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  // tick_q clears on reset, so a level already high at release reads as a rise.
  assign rise = tick_in & ~tick_q;

endmodule

// File: rtl/tick_accumulator.sv
// Extends the upstream counter range and offers snapshots over a valid/ready port.
// Define TICK_ACCUMULATOR_SAT_EN to saturate the accumulator instead of wrapping.
module tick_accumulator
  import tick_acc_pkg::*;
#(
  parameter int unsigned ACC_W = DefaultAccW,
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             clr,
  input  logic             snap,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [ACC_W-1:0] rd_acc,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_ovf,
  output logic             snap_miss
);

  logic             rise;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [ACC_W-1:0] rd_acc_q;
  logic [CNT_W-1:0] rd_count_q;
  logic             rd_ovf_q;
  logic             snap_miss_q;
  logic             capture;
  logic             miss_set;

  rise_detect u_rise_detect (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .rise    (rise)
  );

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (rise) begin
      if (acc_q == {ACC_W{1'b1}}) begin
        ovf_d = 1'b1;
`ifdef TICK_ACCUMULATOR_SAT_EN
        acc_d = acc_q;
`else
        acc_d = '0;
`endif
      end else begin
        acc_d = acc_q + ACC_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    miss_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (snap) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (rd_ready) begin
          // A snap on the accepting edge reloads for back-to-back transfers.
          if (snap) begin
            capture = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (snap) begin
          miss_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      state_q     <= StIdle;
      rd_acc_q    <= '0;
      rd_count_q  <= '0;
      rd_ovf_q    <= 1'b0;
      snap_miss_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      if (capture) begin
        rd_acc_q   <= acc_q;
        rd_count_q <= count_in;
        rd_ovf_q   <= ovf_q;
      end
      if (miss_set) begin
        snap_miss_q <= 1'b1;
      end
    end
  end

  assign rd_valid  = (state_q == StHold);
  assign rd_acc    = rd_acc_q;
  assign rd_count  = rd_count_q;
  assign rd_ovf    = rd_ovf_q;
  assign snap_miss = snap_miss_q;

endmodule

// File: tb/tb_tick_accumulator.sv
// Self-checking bench for tick_accumulator: directed plan steps plus random traffic.
module tb_tick_accumulator;

  localparam int unsigned AccW   = 8;
  localparam int unsigned CntW   = 4;
  localparam int          AccMax = (1 << AccW) - 1;

  logic            clk;
  logic            rst;
  logic            tick_in;
  logic [CntW-1:0] count_in;
  logic            clr;
  logic            snap;
  logic            rd_ready;
  logic            rd_valid;
  logic [AccW-1:0] rd_acc;
  logic [CntW-1:0] rd_count;
  logic            rd_ovf;
  logic            snap_miss;

  tick_accumulator #(
    .ACC_W (AccW),
    .CNT_W (CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .count_in  (count_in),
    .clr       (clr),
    .snap      (snap),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_acc    (rd_acc),
    .rd_count  (rd_count),
    .rd_ovf    (rd_ovf),
    .snap_miss (snap_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers, advanced once per clock edge.
  int m_acc;
  int m_racc;
  int m_rcount;
  bit m_ovf;
  bit m_prev;
  bit m_valid;
  bit m_rovf;
  bit m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit t, input int c, input bit cl, input bit sn, input bit rd,
                            input bit rs);
    bit rise;
    if (rs) begin
      m_acc = 0; m_ovf = 0; m_prev = 0; m_valid = 0;
      m_racc = 0; m_rcount = 0; m_rovf = 0; m_miss = 0;
    end else begin
      rise = t && !m_prev;
      if (sn && (!m_valid || rd)) begin
        m_racc = m_acc; m_rcount = c; m_rovf = m_ovf; m_valid = 1;
      end else if (m_valid && rd) begin
        m_valid = 0;
      end else if (m_valid && sn) begin
        m_miss = 1;
      end
      if (cl) begin
        m_acc = 0; m_ovf = 0;
      end else if (rise) begin
        if (m_acc == AccMax) begin
          m_ovf = 1;
`ifndef TICK_ACCUMULATOR_SAT_EN
          m_acc = 0;
`endif
        end else begin
          m_acc = m_acc + 1;
        end
      end
      m_prev = t;
    end
  endtask

  task automatic cyc(input bit t, input int c, input bit cl, input bit sn, input bit rd,
                     input bit rs);
    tick_in  = t;
    count_in = CntW'(c);
    clr      = cl;
    snap     = sn;
    rd_ready = rd;
    rst      = rs;
    @(posedge clk);
    model_edge(t, c, cl, sn, rd, rs);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_acc", 32'(rd_acc), 32'(m_racc));
    chk("rd_count", 32'(rd_count), 32'(m_rcount));
    chk("rd_ovf", 32'(rd_ovf), 32'(m_rovf));
    chk("snap_miss", 32'(snap_miss), 32'(m_miss));
  endtask

  task automatic pulses(input int n, input int lo, input bit rd);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, rd, 0);
      for (int j = 0; j < lo; j++) cyc(0, 0, 0, 0, rd, 0);
    end
  endtask

  task automatic idle_clr();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
  endtask

  initial begin
    tick_in = 0; count_in = '0; clr = 0; snap = 0; rd_ready = 0; rst = 1;

    // 1: three short pulses, then snapshot with count_in = 1010
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_miss", 32'(snap_miss), 32'd0);
    pulses(3, 2, 0);
    cyc(0, 4'b1010, 0, 1, 0, 0);
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_acc", 32'(rd_acc), 32'd3);
    chk("t1_count", 32'(rd_count), 32'd10);
    chk("t1_ovf", 32'(rd_ovf), 32'd0);

    // 2: a long-high tick counts once
    idle_clr();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t2_acc", 32'(rd_acc), 32'd1);

    // 3: 2^ACC_W rises overflow
    idle_clr();
    pulses(AccMax + 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
`ifdef TICK_ACCUMULATOR_SAT_EN
    chk("t3_acc", 32'(rd_acc), 32'd255);
`else
    chk("t3_acc", 32'(rd_acc), 32'd0);
`endif
    chk("t3_ovf", 32'(rd_ovf), 32'd1);

    // 4: dropped snap while stalled, then back-to-back transfer
    idle_clr();
    pulses(4, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t4_first", 32'(rd_acc), 32'd4);
    pulses(5, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t4_miss", 32'(snap_miss), 32'd1);
    chk("t4_held", 32'(rd_acc), 32'd4);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t4_b2b_valid", 32'(rd_valid), 32'd1);
    chk("t4_b2b_acc", 32'(rd_acc), 32'd9);

    // 5: read-and-clear, then clear beats a same-cycle rise
    idle_clr();
    pulses(7, 1, 1);
    cyc(0, 0, 1, 1, 1, 0);
    chk("t5_rc_acc", 32'(rd_acc), 32'd7);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t5_cleared", 32'(rd_acc), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t5_clr_rise", 32'(rd_acc), 32'd0);

    // 6: reset in HOLD discards the snapshot and sticky miss
    idle_clr();
    pulses(5, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t6_pre_valid", 32'(rd_valid), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t6_valid", 32'(rd_valid), 32'd0);
    chk("t6_miss", 32'(snap_miss), 32'd0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t6_acc", 32'(rd_acc), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
          bit'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_accumulator.md
Name: tick_accumulator

Overview:
- Sits directly downstream of the 4-bit counter. It consumes the counter's `out` terminal pulse (tick_in) and its `count` bus (count_in).
- Counts tick rising edges into a wider accumulator, extending the 4-bit counter's range.
- On request, captures a snapshot of {ovf, accumulator, count_in} and presents it over a valid/ready read port.

Parameters:
- ACC_W, 8, accumulator width in bits (≥2).
- CNT_W, 4, width of count_in / rd_count; matches the upstream counter.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  upstream counter terminal output; a level, may stay high for several cycles.
- count_in  input  CNT_W  upstream counter value, sampled only at snapshot.
- clr  input  1  synchronous clear of accumulator and ovf.
- snap  input  1  snapshot request, single-cycle strobe.
- rd_ready  input  1  consumer accepts the snapshot.
- rd_valid  output  1  snapshot held and valid.
- rd_acc  output  ACC_W  captured accumulator value.
- rd_count  output  CNT_W  captured count_in.
- rd_ovf  output  1  captured overflow flag.
- snap_miss  output  1  sticky: a snap was dropped.

Behaviour:
- Reset (rst=1 at a clk edge): acc=0, ovf=0, tick_q=0, state=IDLE, rd_valid=0, rd_acc=0, rd_count=0, rd_ovf=0, snap_miss=0.
  - rst overrides every other input, including mid-HOLD; a pending snapshot is discarded.
- Edge detect:
  - tick_q registers tick_in.
  - rise = tick_in & ~tick_q.
  - One increment per low→high transition, regardless of high duration.
  - A tick_in already high when rst deasserts counts as a rise on the first cycle after reset.
- Accumulator update, in priority order:
  - clr=1: acc←0, ovf←0. A rise in the same cycle is discarded.
  - else rise=1: acc←acc+1, modulo 2^ACC_W. When acc is all-ones, it wraps to 0 and ovf←1 (sticky until clr/rst).
- FSM with two states, IDLE and HOLD.
  - IDLE, snap=1:
    - Capture rd_acc←acc, rd_count←count_in, rd_ovf←ovf. All three are pre-update register values of this cycle, so they are unaffected by a same-cycle rise or clr.
    - Go to HOLD. rd_valid=1 from the next cycle (latency 1).
  - IDLE, snap=0: stay IDLE.
  - HOLD, rd_ready=1, snap=0: transfer completes → IDLE, rd_valid=0 next cycle.
  - HOLD, rd_ready=1, snap=1: transfer completes and a new capture occurs in the same edge. Stay HOLD; rd_valid stays 1 with new data (back-to-back).
  - HOLD, rd_ready=0, snap=1: snap dropped, snap_miss←1. Captured data unchanged.
  - HOLD, rd_ready=0, snap=0: hold all rd_* outputs stable.
- rd_ready in IDLE is ignored.
- snap_miss clears only on rst.
- clr+snap in the same cycle gives read-and-clear: the snapshot holds the old value and acc=0 next cycle.

Optional Feature:
- Macro: TICK_ACCUMULATOR_SAT_EN.
- Defined: acc saturates at 2^ACC_W−1. A rise at saturation leaves acc unchanged and sets ovf←1.
- Undefined: wrap-around behaviour as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package tick_acc_pkg:
  - state encoding (IDLE=1'b0, HOLD=1'b1)
  - default ACC_W=8
  - CNT_W=4, shared with the upstream counter
- One natural sub-module: rise_detect, holding the tick_q register and the rise output, with synchronous active-high rst.
- The accumulator and FSM stay in tick_accumulator.

Test Plan:
1. Reset, then three tick_in pulses, each 1 cycle high and 2 low. Then snap with count_in=4'b1010. → Next cycle rd_valid=1, rd_acc=3, rd_count=4'b1010, rd_ovf=0.
2. tick_in held high for 5 cycles, then low. → acc increments by exactly 1.
3. 256 rises with ACC_W=8, then snap. → rd_acc=0, rd_ovf=1. With TICK_ACCUMULATOR_SAT_EN defined → rd_acc=255, rd_ovf=1.
4. Snap, hold rd_ready=0, snap again. → snap_miss=1, rd_* unchanged. Then rd_ready=1 with snap=1 and acc=9. → rd_valid stays 1, rd_acc=9.
5. acc=7, clr=1 and snap=1 in the same cycle. → rd_acc=7, acc=0 next cycle. Then clr=1 with a rise in the same cycle. → acc stays 0.
6. rst=1 while in HOLD with rd_valid=1 and acc=5. → next cycle rd_valid=0, acc=0, snap_miss=0, state IDLE.
